// File: rtl/permu_opreq_scheduler_if.sv
// rtl/permu_opreq_scheduler_if.sv - request/queue/VRF bundle for permu_opreq_scheduler
//
// Purpose: groups the requester handshake, operand-queue command/credit and
//   VRF row-read signals of the permutation operand request scheduler.
// Parameters: NrReq, AddrWidth, VLEN (sizes vlen_t), FuW (target_fu_e width).
// Modports:
//   slave  - the scheduler: consumes req_*, opq_cmd_pop_i, opq_ready_i, vrf_gnt_i;
//            drives req_ready_o, done_o, opq_cmd_o/valid_o, vrf_req_o/addr_o, operand_issued_o.
//   master - the surrounding environment (requesters, queue, VRF), opposite directions.
// Command layout (operand_queue_cmd_t, packed MSB->LSB): elem_count, target_fu, conv.

interface opreq_if #(
  parameter int NrReq     = 2,
  parameter int AddrWidth = 8,
  parameter int VLEN      = 0,
  parameter int FuW       = 3
);
  // A zero VLEN leaves vlen_t undefined; fall back to an 8-bit row count.
  localparam int VlenW = (VLEN > 0) ? $clog2(VLEN + 1) : 8;

  typedef logic [VlenW-1:0] vlen_t;
  typedef logic [FuW-1:0]   target_fu_e;

  typedef struct packed {
    vlen_t      elem_count;
    target_fu_e target_fu;
    logic [1:0] conv;
  } operand_queue_cmd_t;

  logic [NrReq-1:0]                req_valid_i;
  logic [NrReq-1:0]                req_ready_o;
  logic [NrReq-1:0][AddrWidth-1:0] req_addr_i;
  logic [NrReq-1:0][VlenW-1:0]     req_rows_i;
  logic [NrReq-1:0][FuW-1:0]       req_target_fu_i;
  logic [NrReq-1:0]                done_o;

  operand_queue_cmd_t              opq_cmd_o;
  logic                            opq_cmd_valid_o;
  logic                            opq_cmd_pop_i;
  logic                            opq_ready_i;

  logic                            vrf_req_o;
  logic [AddrWidth-1:0]            vrf_addr_o;
  logic                            vrf_gnt_i;
  logic                            operand_issued_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_rows_i, req_target_fu_i,
    input  opq_cmd_pop_i, opq_ready_i, vrf_gnt_i,
    output req_ready_o, done_o, opq_cmd_o, opq_cmd_valid_o,
    output vrf_req_o, vrf_addr_o, operand_issued_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_rows_i, req_target_fu_i,
    output opq_cmd_pop_i, opq_ready_i, vrf_gnt_i,
    input  req_ready_o, done_o, opq_cmd_o, opq_cmd_valid_o,
    input  vrf_req_o, vrf_addr_o, operand_issued_o
  );
endinterface

// File: rtl/permu_opreq_scheduler.sv
// rtl/permu_opreq_scheduler.sv - round-robin VRF row-read scheduler feeding operand_permu_queue
//
// Purpose: shares one operand queue between NrReq requesters. A round-robin pick
//   accepts one request, pushes one command into the queue's command FIFO, then
//   issues one row read (one elen_t word from every bank) per granted cycle, only
//   while the queue reports credit.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous reset, active-low
//   flush_i  - synchronous abort: back to IDLE, command count cleared, no done_o
//   bus      - opreq_if.slave: requester handshake, queue command/credit, VRF read
//   stall_credit_o / stall_gnt_o - 32-bit saturating stall counters, present only
//              when PERMU_OPREQ_PERF_EN is defined
// Optional feature macro: PERMU_OPREQ_PERF_EN

module permu_opreq_scheduler #(
  parameter int NrReq       = 2,
  parameter int CmdBufDepth = 2,
  parameter int AddrWidth   = 8,
  parameter int VLEN        = 0,
  parameter int FuW         = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  opreq_if.slave      bus
`ifdef PERMU_OPREQ_PERF_EN
  ,
  output logic [31:0] stall_credit_o,
  output logic [31:0] stall_gnt_o
`endif
);

  localparam int VlenW = (VLEN > 0) ? $clog2(VLEN + 1) : 8;
  localparam int IdxW  = $clog2(NrReq);
  localparam int CntW  = $clog2(CmdBufDepth + 1);

  localparam logic [1:0] OpQueueConversionNone = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [IdxW-1:0]      gnt_q, gnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [VlenW-1:0]     rem_q, rem_d;
  logic [FuW-1:0]       fu_q, fu_d;
  logic [CntW-1:0]      cmd_cnt_q, cmd_cnt_d;
  logic [NrReq-1:0]     zdone_q, zdone_d;

  logic [NrReq-1:0]     req_ready;
  logic [NrReq-1:0]     done;
  logic                 cmd_push;
  logic                 vrf_req;
  logic                 issued;

  // Round-robin pick: first valid requester at or after rr_q, wrapping at NrReq.
  logic                 found;
  logic [IdxW-1:0]      sel;
  logic [IdxW:0]        probe;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    probe = '0;
    for (int k = 0; k < NrReq; k++) begin
      probe = {1'b0, rr_q} + (IdxW + 1)'(k);
      if (probe >= (IdxW + 1)'(NrReq)) begin
        probe = probe - (IdxW + 1)'(NrReq);
      end
      if (!found && bus.req_valid_i[probe[IdxW-1:0]]) begin
        found = 1'b1;
        sel   = probe[IdxW-1:0];
      end
    end
  end

  logic cmd_slot_free;
  assign cmd_slot_free = (cmd_cnt_q < CntW'(CmdBufDepth));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    fu_d      = fu_q;
    zdone_d   = '0;
    req_ready = '0;
    // A zero-row request completes the cycle after its accept, with no command or read.
    done      = zdone_q;
    cmd_push  = 1'b0;
    vrf_req   = 1'b0;
    issued    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[sel] = 1'b1;
          gnt_d          = sel;
          addr_d         = bus.req_addr_i[sel];
          rem_d          = bus.req_rows_i[sel];
          fu_d           = bus.req_target_fu_i[sel];
          rr_d           = (sel == IdxW'(NrReq - 1)) ? '0 : sel + 1'b1;
          if (bus.req_rows_i[sel] == '0) begin
            zdone_d[sel] = 1'b1;
          end else begin
            state_d = CMD;
          end
        end
      end

      CMD: begin
        if (cmd_slot_free) begin
          cmd_push = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        // Reads are requested only with queue credit, so a granted row always lands.
        vrf_req = bus.opq_ready_i;
        if (vrf_req && bus.vrf_gnt_i) begin
          issued = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == VlenW'(1)) begin
            done[gnt_q] = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d   = IDLE;
      rr_d      = rr_q;
      zdone_d   = '0;
      req_ready = '0;
      done      = '0;
      cmd_push  = 1'b0;
      vrf_req   = 1'b0;
      issued    = 1'b0;
    end
  end

  // Mirror of the queue's command FIFO occupancy; push and pop together cancel.
  always_comb begin
    cmd_cnt_d = cmd_cnt_q;
    if (flush_i) begin
      cmd_cnt_d = '0;
    end else if (cmd_push && !bus.opq_cmd_pop_i) begin
      cmd_cnt_d = cmd_cnt_q + 1'b1;
    end else if (!cmd_push && bus.opq_cmd_pop_i && (cmd_cnt_q != '0)) begin
      cmd_cnt_d = cmd_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      fu_q      <= '0;
      cmd_cnt_q <= '0;
      zdone_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      fu_q      <= fu_d;
      cmd_cnt_q <= cmd_cnt_d;
      zdone_q   <= zdone_d;
    end
  end

  // rem_q still holds the full row count while in CMD, which is the only time the
  // command is pushed.
  assign bus.opq_cmd_o        = {rem_q, fu_q, OpQueueConversionNone};
  assign bus.opq_cmd_valid_o  = cmd_push;
  assign bus.req_ready_o      = req_ready;
  assign bus.done_o           = done;
  assign bus.vrf_req_o        = vrf_req;
  assign bus.vrf_addr_o       = addr_q;
  assign bus.operand_issued_o = issued;

`ifdef PERMU_OPREQ_PERF_EN
  logic [31:0] stall_credit_q, stall_gnt_q;

  // The two stall causes are disjoint: vrf_req already implies queue credit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_credit_q <= '0;
      stall_gnt_q    <= '0;
    end else if (state_q == ISSUE) begin
      if (!bus.opq_ready_i && (stall_credit_q != '1)) begin
        stall_credit_q <= stall_credit_q + 32'd1;
      end
      if (vrf_req && !bus.vrf_gnt_i && (stall_gnt_q != '1)) begin
        stall_gnt_q <= stall_gnt_q + 32'd1;
      end
    end
  end

  assign stall_credit_o = stall_credit_q;
  assign stall_gnt_o    = stall_gnt_q;
`else
  // Stall counters are not built in this configuration.
`endif

endmodule
